// File: rtl/mem_responder_pkg.sv
// Shared bus encodings, tag type and outstanding-request entry for the memory responder.
package mem_responder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CD_W  = 6;

    typedef logic [TAG_W-1:0] MEM_TAG;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_e;

    typedef struct packed {
        MEM_TAG            tag;
        logic [63:0]       data;
        logic [CD_W-1:0]   countdown;
    } MEM_REQ_ENTRY;

    // Round-robin tag sequence 1..num_tags; 0 is reserved for "none".
    function automatic MEM_TAG tag_advance(input MEM_TAG t, input int unsigned num_tags);
        return (t == TAG_W'(num_tags)) ? TAG_W'(1) : t + TAG_W'(1);
    endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// In-order queue of outstanding requests; every entry ages one cycle per clock.
module mem_resp_fifo
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  MEM_REQ_ENTRY                 push_entry,
    input  logic                         pop,
    output MEM_REQ_ENTRY                 head_entry_c,
    output logic                         head_expired_c,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    MEM_REQ_ENTRY     entries_q [DEPTH];
    MEM_REQ_ENTRY     entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].countdown != '0) begin
                entries_d[i].countdown = entries_q[i].countdown - CD_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            entries_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Head is due when its remaining count reaches 1: the output register loads at this edge.
    assign head_entry_c   = entries_q[rd_ptr_q];
    assign head_expired_c = (count_q != '0) && (head_entry_c.countdown == CD_W'(1));
    assign count          = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory responder for the core's external bus.
// Optional random back-pressure when MEM_RESP_STALL_EN is defined.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned LATENCY   = 10,
    parameter int unsigned NUM_TAGS  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [XLEN-1:0]   proc2mem_addr,
    input  logic [63:0]       proc2mem_data,
    output logic [TAG_W-1:0]  mem2proc_response,
    output logic [63:0]       mem2proc_data,
    output logic [TAG_W-1:0]  mem2proc_tag
);

    localparam int unsigned IDX_W = XLEN - 3;
    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

    logic [63:0]      mem_q [MEM_WORDS];
    MEM_TAG           next_tag_q, next_tag_d;
    MEM_TAG           mem2proc_tag_q, mem2proc_tag_d;
    logic [63:0]      mem2proc_data_q, mem2proc_data_d;

    logic [IDX_W-1:0] idx_c;
    logic [AW-1:0]    widx_c;
    logic             in_range_c, is_load_c, is_store_c;
    logic             accept_c, push_c, pop_c, mem_we_c, stall_c;
    MEM_REQ_ENTRY     push_entry_c, head_entry_c;
    logic             head_expired_c;
    logic [CNT_W-1:0] count;
    logic             unused_c;

`ifdef MEM_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 8'h5A;
        else       lfsr_q <= lfsr_d;
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_c = 1'b0;
`endif

    assign unused_c = ^{proc2mem_addr[2:0], head_entry_c.countdown};

    always_comb begin
        idx_c      = proc2mem_addr[XLEN-1:3];
        widx_c     = idx_c[AW-1:0];
        in_range_c = (idx_c < IDX_W'(MEM_WORDS));
        is_load_c  = (proc2mem_command == BUS_LOAD);
        is_store_c = (proc2mem_command == BUS_STORE);
        pop_c      = head_expired_c;
        // A slot freed by this cycle's pop is immediately reusable.
        accept_c   = !reset && !stall_c && (is_load_c || is_store_c)
                     && ((count < CNT_W'(NUM_TAGS)) || pop_c);
        push_c     = accept_c && (LATENCY > 1);
        mem_we_c   = accept_c && is_store_c && in_range_c;

        mem2proc_response = accept_c ? next_tag_q : '0;

        push_entry_c.tag       = next_tag_q;
        push_entry_c.data      = '0;
        push_entry_c.countdown = CD_W'(LATENCY - 1);
        if (is_load_c) begin
            push_entry_c.data = in_range_c ? mem_q[widx_c] : '1;
        end

        next_tag_d = accept_c ? tag_advance(next_tag_q, NUM_TAGS) : next_tag_q;

        mem2proc_tag_d  = '0;
        mem2proc_data_d = '0;
        if (LATENCY == 1) begin
            if (accept_c) begin
                mem2proc_tag_d  = push_entry_c.tag;
                mem2proc_data_d = push_entry_c.data;
            end
        end else if (pop_c) begin
            mem2proc_tag_d  = head_entry_c.tag;
            mem2proc_data_d = head_entry_c.data;
        end
    end

    mem_resp_fifo #(
        .DEPTH (NUM_TAGS)
    ) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .push           (push_c),
        .push_entry     (push_entry_c),
        .pop            (pop_c),
        .head_entry_c   (head_entry_c),
        .head_expired_c (head_expired_c),
        .count          (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag_q      <= TAG_W'(1);
            mem2proc_tag_q  <= '0;
            mem2proc_data_q <= '0;
        end else begin
            next_tag_q      <= next_tag_d;
            mem2proc_tag_q  <= mem2proc_tag_d;
            mem2proc_data_q <= mem2proc_data_d;
        end
    end

    // Backing store survives reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[widx_c] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = mem2proc_tag_q;
    assign mem2proc_data = mem2proc_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: port A uses default latency 10, port B latency 20 to reach the full condition.
module tb_mem_responder;
    import mem_responder_pkg::*;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cmd_a = 2'b00, cmd_b = 2'b00;
    logic [31:0] addr_a = '0, addr_b = '0;
    logic [63:0] wdata_a = '0, wdata_b = '0;
    logic [3:0]  resp_a, resp_b, tag_a, tag_b;
    logic [63:0] data_a, data_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    localparam logic [63:0] PRE  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] OOR  = 32'h0001_0000;

    mem_responder dut_a (
        .clock(clock), .reset(reset), .proc2mem_command(cmd_a), .proc2mem_addr(addr_a),
        .proc2mem_data(wdata_a), .mem2proc_response(resp_a), .mem2proc_data(data_a),
        .mem2proc_tag(tag_a)
    );

    mem_responder #(.LATENCY(20)) dut_b (
        .clock(clock), .reset(reset), .proc2mem_command(cmd_b), .proc2mem_addr(addr_b),
        .proc2mem_data(wdata_b), .mem2proc_response(resp_b), .mem2proc_data(data_b),
        .mem2proc_tag(tag_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic judge(input string name, input logic [3:0] t, input logic [63:0] d,
                         input bit have, input exp_t e);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected completion: got tag=%0d data=%h cycle=%0d, required none",
                     name, t, d, cyc);
        end else if (t !== e.tag || d !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL %s completion: got tag=%0d data=%h cycle=%0d, required tag=%0d data=%h cycle=%0d",
                     name, t, d, cyc, e.tag, e.data, e.due);
        end
    endtask

    task automatic missed(input string name, input exp_t e);
        n_tests++;
        n_fail++;
        $display("FAIL %s missing completion: got tag=0 at cycle %0d, required tag=%0d at cycle %0d",
                 name, cyc, e.tag, e.due);
    endtask

    // Monitors: pop the scoreboard whenever a tag completes.
    always @(negedge clock) begin
        exp_t e;
        e = '0;
        if (tag_a != 4'd0) begin
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                judge("port_a", tag_a, data_a, 1'b1, e);
            end else begin
                judge("port_a", tag_a, data_a, 1'b0, e);
            end
        end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            missed("port_a", e);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        e = '0;
        if (tag_b != 4'd0) begin
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                judge("port_b", tag_b, data_b, 1'b1, e);
            end else begin
                judge("port_b", tag_b, data_b, 1'b0, e);
            end
        end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            missed("port_b", e);
        end
    end

    // Present one command for one cycle, check the same-cycle response, queue the expected completion.
    task automatic step_cmd(input bit b, input logic [1:0] cmd, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [3:0] exp_resp,
                            input logic [63:0] exp_data, input bit track = 1'b1);
        logic [3:0] act;
        exp_t e;
        if (b) begin cmd_b = cmd; addr_b = addr; wdata_b = wd; end
        else   begin cmd_a = cmd; addr_a = addr; wdata_a = wd; end
        @(negedge clock);
        act = b ? resp_b : resp_a;
        n_tests++;
        if (act !== exp_resp) begin
            n_fail++;
            $display("FAIL %s response cycle %0d: got %0d, required %0d",
                     b ? "port_b" : "port_a", cyc, act, exp_resp);
        end
        if (exp_resp != 4'd0 && track) begin
            e.tag  = exp_resp;
            e.data = exp_data;
            e.due  = cyc + (b ? 20 : 10);
            if (b) q_b.push_back(e);
            else   q_a.push_back(e);
        end
        @(posedge clock);
        #1;
        cmd_a = BUS_NONE;
        cmd_b = BUS_NONE;
    endtask

    task automatic idle(input bit b, input int n);
        for (int i = 0; i < n; i++) step_cmd(b, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        cmd_a  = BUS_LOAD; addr_a = 32'h40;
        cmd_b  = BUS_LOAD; addr_b = 32'h40;
        @(negedge clock);
        n_tests++;
        if (resp_a !== 4'd0 || resp_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_response: got a=%0d b=%0d, required 0", resp_a, resp_b);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmd_a = BUS_NONE;
        cmd_b = BUS_NONE;
        n_tests++;
        if (tag_a !== 4'd0 || data_a !== 64'h0 || tag_b !== 4'd0 || data_b !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tag_a=%0d data_a=%h tag_b=%0d data_b=%h, required zeros",
                     tag_a, data_a, tag_b, data_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        do_reset();
        // Preload word 8 through the bus, then start test 1 from a fresh reset.
        step_cmd(0, BUS_STORE, 32'h40, PRE, 4'd1, 64'h0);
        idle(0, 11);
        do_reset();

        // Test 1: single load, fixed latency.
        step_cmd(0, BUS_LOAD, 32'h40, 64'h0, 4'd1, PRE);
        idle(0, 12);

        // Test 2: store then load of the same word on the next cycle.
        do_reset();
        step_cmd(0, BUS_STORE, 32'h100, 64'hA5A5, 4'd1, 64'h0);
        step_cmd(0, BUS_LOAD,  32'h100, 64'h0,    4'd2, 64'hA5A5);
        idle(0, 12);

        // Test 4: out-of-range load/store; in-range words untouched; offset bits ignored.
        do_reset();
        step_cmd(0, BUS_LOAD,  OOR,          64'h0,          4'd1, ONES);
        step_cmd(0, BUS_STORE, OOR,          64'hDEAD_BEEF,  4'd2, 64'h0);
        step_cmd(0, BUS_LOAD,  OOR + 32'h40, 64'h0,          4'd3, ONES);
        step_cmd(0, BUS_LOAD,  32'h40,       64'h0,          4'd4, PRE);
        step_cmd(0, BUS_LOAD,  32'h107,      64'h0,          4'd5, 64'hA5A5);
        idle(0, 12);

        // Test 5: reset with three loads in flight discards them.
        do_reset();
        step_cmd(0, BUS_LOAD, 32'h40,  64'h0, 4'd1, PRE, 1'b0);
        step_cmd(0, BUS_LOAD, 32'h100, 64'h0, 4'd2, 64'hA5A5, 1'b0);
        step_cmd(0, BUS_LOAD, 32'h40,  64'h0, 4'd3, PRE, 1'b0);
        do_reset();
        step_cmd(0, BUS_LOAD, 32'h100, 64'h0, 4'd1, 64'hA5A5);
        idle(0, 14);

        // Test 3 (latency 20): fill all 15 tags, stall, then reuse the freed slot.
        do_reset();
        for (int i = 0; i < 15; i++) step_cmd(1, BUS_LOAD, OOR, 64'h0, 4'(i + 1), ONES);
        for (int i = 15; i < 19; i++) step_cmd(1, BUS_LOAD, OOR, 64'h0, 4'd0, ONES);
        step_cmd(1, BUS_LOAD, OOR, 64'h0, 4'd1, ONES);
        for (int i = 0; i < 4; i++) step_cmd(1, BUS_LOAD, OOR, 64'h0, 4'(i + 2), ONES);
        idle(1, 24);

        n_tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
